debug_cmd_sequencer: RTL and testbench
======================================

DEBUG_CMD_SEQUENCER -- requirements
Module: debug_cmd_sequencer

Interface
REQ-001 Parameters SHALL be: NB_DATA 8 (UART byte width); NB_INST 32 (instruction width, multiple of NB_DATA); INST_DEPTH 64 (program words); NB_STEP 8 (step-counter width); RESP_BYTES 260 (debug-unit bytes returned per step); TIMEOUT_CYC 2^20 (watchdog limit).
REQ-002 i_clock  in  1  single system clock; all logic on its rising edge.
REQ-003 i_reset  in  1  asynchronous, active-low reset.
REQ-004 i_start  in  1  one-cycle run request; ignored while o_busy=1.
REQ-005 i_mode  in  1  0 = continuous run, 1 = step-by-step run.
REQ-006 i_n_inst  in  clog2(INST_DEPTH+1)  number of program words to send.
REQ-007 i_n_steps  in  NB_STEP  number of steps in step mode.
REQ-008 i_prog_we / i_prog_addr / i_prog_data  in  1 / clog2(INST_DEPTH) / NB_INST  program-buffer write port.
REQ-009 o_tx_data  out  NB_DATA  byte to UART transmitter.
REQ-010 o_tx_start  out  1  one-cycle transmit pulse.
REQ-011 i_tx_done_tick  in  1  transmitter finished the current byte.
REQ-012 i_rx_done_tick  in  1  one byte received from debug unit (data not inspected).
REQ-013 o_busy, o_done, o_error  out  1 each  running; run finished (1-cycle pulse); watchdog fired (sticky).
REQ-014 o_state  out  4  current FSM state encoding.
REQ-015 o_step_count  out  NB_STEP  completed steps in the current run.

Function
REQ-016 FSM states SHALL be IDLE, CMD_LOAD, SEND_WORD, WAIT_TX, CMD_MODE, CMD_STEP, WAIT_RESP, CMD_RESUME, FINISH, ERROR.
REQ-017 IDLE + i_start: if i_n_inst>0 go CMD_LOAD (send 0x01), else go CMD_MODE directly.
REQ-018 After WRITE_IM, each of the i_n_inst words SHALL be sent as NB_INST/NB_DATA bytes, MSB byte first, words in ascending address order from 0.
REQ-019 Every byte: o_tx_data valid and o_tx_start pulsed for exactly one cycle; next o_tx_start only after i_tx_done_tick for the previous byte; no tx_start on the same cycle as tx_done.
REQ-020 CMD_MODE SHALL send 0x02 (continuous) or 0x03 (step); continuous mode goes to FINISH after that byte's tx_done.
REQ-021 Step mode: repeat i_n_steps times {send 0x07; WAIT_RESP until RESP_BYTES i_rx_done_ticks counted; increment o_step_count}; then send 0x08 (CMD_RESUME) and go FINISH.
REQ-022 i_n_steps=0 in step mode SHALL send 0x03 then 0x08 with no 0x07.
REQ-023 rx ticks outside WAIT_RESP SHALL be ignored; a tick simultaneous with entry to WAIT_RESP counts.
REQ-024 FINISH pulses o_done one cycle, returns to IDLE; o_busy=1 in every state except IDLE and ERROR.
REQ-025 i_mode, i_n_inst, i_n_steps SHALL be captured at i_start; later changes do not affect the run.
REQ-026 Program writes while o_busy=1 SHALL be ignored; writes in IDLE take effect next cycle.
REQ-027 ERROR is left only via reset.

Reset
REQ-028 On i_reset=0: state IDLE, o_tx_start 0, o_tx_data 0, o_busy 0, o_done 0, o_error 0, o_step_count 0, all counters 0; program buffer contents not cleared.
REQ-029 Reset asserted mid-run SHALL abort immediately without emitting further bytes.

Configuration
REQ-030 With SEQ_TIMEOUT_EN defined: a counter reset on every state change and on each tx/rx tick; reaching TIMEOUT_CYC in WAIT_TX or WAIT_RESP enters ERROR, sets o_error, clears o_busy.
REQ-031 Without SEQ_TIMEOUT_EN: waits indefinitely, o_error tied 0, ERROR unreachable.

Structure
REQ-032 Package dbg_seq_pkg SHALL hold command codes (CMD_WRITE_IM=1, CMD_CONT=2, CMD_STEP=3, CMD_NEXT=7, CMD_RESUME=8) and the state enumeration.
REQ-033 Program buffer SHALL be sub-module seq_prog_ram (1 write, 1 synchronous read port, depth INST_DEPTH).

Verification
REQ-034 Load words 0x8C010004,0x00000000; n_inst=2, mode=0, start -> bytes 01,8C,01,00,04,00,00,00,00,02 then o_done.
REQ-035 n_inst=0, mode=1, n_steps=2, RESP_BYTES rx ticks after each 07 -> bytes 03,07,07,08; o_step_count=2.
REQ-036 Step mode, n_steps=0 -> bytes 03,08; no WAIT_RESP entry.
REQ-037 SEQ_TIMEOUT_EN, TIMEOUT_CYC=100, withhold tx_done after first byte -> o_error=1 at cycle 100, o_busy=0; further i_start ignored.
REQ-038 Reset pulse during WAIT_RESP -> all outputs at reset values next cycle; new run from address 0 transmits correctly.
REQ-039 i_start and i_prog_we during busy -> ignored; buffer and byte stream unchanged.

Source files
------------

// File: rtl/dbg_seq_pkg.sv
// dbg_seq_pkg: debug-unit command codes and sequencer state encoding.
package dbg_seq_pkg;
  localparam logic [7:0] CMD_WRITE_IM = 8'h01;
  localparam logic [7:0] CMD_CONT     = 8'h02;
  localparam logic [7:0] CMD_STEP     = 8'h03;
  localparam logic [7:0] CMD_NEXT     = 8'h07;
  localparam logic [7:0] CMD_RESUME   = 8'h08;
  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_CMD_LOAD   = 4'd1,
    S_SEND_WORD  = 4'd2,
    S_WAIT_TX    = 4'd3,
    S_CMD_MODE   = 4'd4,
    S_CMD_STEP   = 4'd5,
    S_WAIT_RESP  = 4'd6,
    S_CMD_RESUME = 4'd7,
    S_FINISH     = 4'd8,
    S_ERROR      = 4'd9
  } state_t;
endpackage

// File: rtl/seq_prog_ram.sv
// seq_prog_ram: program buffer with one write port and one registered read port.
module seq_prog_ram #(
  parameter int NB_INST    = 32,
  parameter int INST_DEPTH = 64,
  localparam int AW        = $clog2(INST_DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [NB_INST-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [NB_INST-1:0] rdata
);
  logic [NB_INST-1:0] mem [INST_DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/debug_cmd_sequencer.sv
// debug_cmd_sequencer: streams program words and run/step commands to a debug unit over UART.
// Define SEQ_TIMEOUT_EN to add a watchdog that traps stalled handshakes in the ERROR state.
module debug_cmd_sequencer
  import dbg_seq_pkg::*;
#(
  parameter int NB_DATA     = 8,
  parameter int NB_INST     = 32,
  parameter int INST_DEPTH  = 64,
  parameter int NB_STEP     = 8,
  parameter int RESP_BYTES  = 260,
  parameter int TIMEOUT_CYC = 2**20,
  localparam int AW         = $clog2(INST_DEPTH),
  localparam int NW         = $clog2(INST_DEPTH + 1)
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_mode,
  input  logic [NW-1:0]      i_n_inst,
  input  logic [NB_STEP-1:0] i_n_steps,
  input  logic               i_prog_we,
  input  logic [AW-1:0]      i_prog_addr,
  input  logic [NB_INST-1:0] i_prog_data,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done_tick,
  input  logic               i_rx_done_tick,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_error,
  output logic [3:0]         o_state,
  output logic [NB_STEP-1:0] o_step_count
);
  localparam int NBYTE = NB_INST / NB_DATA;
  localparam int BW    = NBYTE > 1 ? $clog2(NBYTE) : 1;
  localparam int RW    = $clog2(RESP_BYTES + 1);
  state_t state, state_n, ret, after_tx;
  logic mode_q, last_byte, rx_hit, timeout, resp_full;
  logic [NW-1:0] n_inst_q, word_idx;
  logic [NB_STEP-1:0] n_steps_q, step_cnt;
  logic [BW-1:0] byte_idx;
  logic [RW-1:0] rx_cnt, rx_next;
  logic [NB_INST-1:0] rd_data;
  logic [NB_DATA-1:0] cur_byte;

  seq_prog_ram #(.NB_INST(NB_INST), .INST_DEPTH(INST_DEPTH)) u_ram (
    .clk(i_clock), .we(i_prog_we && !o_busy), .waddr(i_prog_addr), .wdata(i_prog_data),
    .raddr(word_idx[AW-1:0]), .rdata(rd_data)
  );

  assign cur_byte  = rd_data[NB_INST - 1 - int'(byte_idx) * NB_DATA -: NB_DATA];
  assign last_byte = byte_idx == BW'(NBYTE - 1);
  // the tick that coincides with the NEXT byte's tx_done is the first response byte
  assign rx_hit    = i_rx_done_tick && (state == S_WAIT_RESP ||
                     (state == S_WAIT_TX && ret == S_CMD_STEP && i_tx_done_tick));
  assign rx_next   = rx_cnt + RW'(rx_hit);
  assign resp_full = state == S_WAIT_RESP && rx_next == RW'(RESP_BYTES);

`ifdef SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wd;
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) wd <= '0;
    else wd <= (state_n != state || i_tx_done_tick || i_rx_done_tick) ? '0 : wd + TW'(1);
  assign timeout = wd == TW'(TIMEOUT_CYC - 1) && !i_tx_done_tick && !i_rx_done_tick;
  assign o_error = state == S_ERROR;
`else
  assign timeout = TIMEOUT_CYC < 1;
  assign o_error = 1'b0;
`endif

  always_comb begin
    after_tx = ret == S_CMD_LOAD  ? S_SEND_WORD :
               ret == S_SEND_WORD ? (word_idx == n_inst_q ? S_CMD_MODE : S_SEND_WORD) :
               ret == S_CMD_MODE  ? (!mode_q ? S_FINISH : step_cnt == n_steps_q ? S_CMD_RESUME : S_CMD_STEP) :
               ret == S_CMD_STEP  ? S_WAIT_RESP : S_FINISH;
    state_n = state;
    case (state)
      S_IDLE:      if (i_start) state_n = i_n_inst != '0 ? S_CMD_LOAD : S_CMD_MODE;
      S_CMD_LOAD, S_SEND_WORD, S_CMD_MODE, S_CMD_STEP, S_CMD_RESUME: state_n = S_WAIT_TX;
      S_WAIT_TX:   state_n = i_tx_done_tick ? after_tx : timeout ? S_ERROR : state;
      S_WAIT_RESP: state_n = resp_full ? (step_cnt + 1'b1 == n_steps_q ? S_CMD_RESUME : S_CMD_STEP) :
                             timeout ? S_ERROR : state;
      S_FINISH:    state_n = S_IDLE;
      default:     state_n = state;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) begin
      state     <= S_IDLE;
      ret       <= S_IDLE;
      mode_q    <= 1'b0;
      n_inst_q  <= '0;
      n_steps_q <= '0;
      word_idx  <= '0;
      byte_idx  <= '0;
      step_cnt  <= '0;
      rx_cnt    <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && i_start) begin
        mode_q    <= i_mode;
        n_inst_q  <= i_n_inst;
        n_steps_q <= i_n_steps;
        word_idx  <= '0;
        byte_idx  <= '0;
        step_cnt  <= '0;
      end
      if (o_tx_start) ret <= state;
      if (state == S_SEND_WORD) begin
        byte_idx <= last_byte ? '0 : byte_idx + 1'b1;
        if (last_byte) word_idx <= word_idx + 1'b1;
      end
      if (state == S_CMD_STEP) rx_cnt <= '0;
      else if (rx_hit) rx_cnt <= rx_next;
      if (resp_full) step_cnt <= step_cnt + 1'b1;
    end

  assign o_tx_start   = state inside {S_CMD_LOAD, S_SEND_WORD, S_CMD_MODE, S_CMD_STEP, S_CMD_RESUME};
  assign o_tx_data    = state == S_CMD_LOAD   ? NB_DATA'(CMD_WRITE_IM) :
                        state == S_SEND_WORD  ? cur_byte :
                        state == S_CMD_MODE   ? NB_DATA'(mode_q ? CMD_STEP : CMD_CONT) :
                        state == S_CMD_STEP   ? NB_DATA'(CMD_NEXT) :
                        state == S_CMD_RESUME ? NB_DATA'(CMD_RESUME) : '0;
  assign o_busy       = state != S_IDLE && state != S_ERROR;
  assign o_done       = state == S_FINISH;
  assign o_state      = state;
  assign o_step_count = step_cnt;
endmodule

// File: tb/tb_debug_cmd_sequencer.sv
// tb_debug_cmd_sequencer: directed checks of byte streams, step handshakes, reset and watchdog.
module tb_debug_cmd_sequencer;
  logic clk = 0, rst_n = 1, start = 0, mode = 0, prog_we = 0, tx_done = 0, rx_done = 0;
  logic [6:0] n_inst = 0;
  logic [7:0] n_steps = 0;
  logic [5:0] prog_addr = 0;
  logic [31:0] prog_data = 0;
  logic [7:0] tx_data, step_count;
  logic tx_start, busy, done, error;
  logic [3:0] state;
  int compared = 0, mismatched = 0;
  logic [7:0] full_stream [10] = '{8'h01, 8'h8C, 8'h01, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02};

  debug_cmd_sequencer #(.TIMEOUT_CYC(100)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_start(start), .i_mode(mode), .i_n_inst(n_inst),
    .i_n_steps(n_steps), .i_prog_we(prog_we), .i_prog_addr(prog_addr), .i_prog_data(prog_data),
    .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_done_tick(tx_done), .i_rx_done_tick(rx_done),
    .o_busy(busy), .o_done(done), .o_error(error), .o_state(state), .o_step_count(step_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " state"}, state, 0);
    check({tag, " tx_start"}, tx_start, 0);
    check({tag, " tx_data"}, tx_data, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " error"}, error, 0);
    check({tag, " step_count"}, step_count, 0);
  endtask

  task automatic write_word(input logic [5:0] a, input logic [31:0] d);
    prog_we = 1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 0;
  endtask

  task automatic launch(input logic m, input logic [6:0] ni, input logic [7:0] ns);
    mode = m; n_inst = ni; n_steps = ns; start = 1;
    tick();
    start = 0;
  endtask

  // waits for a transmit pulse, checks the byte, then acknowledges it two cycles later
  task automatic byte_hs(input logic [7:0] exp, input bit stray, input string tag);
    int n = 0;
    while (tx_start !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check({tag, " start"}, tx_start, 1);
    check({tag, " data"}, tx_data, exp);
    tick();
    check({tag, " pulse"}, tx_start, 0);
    rx_done = stray;
    tick();
    rx_done = 0;
    tx_done = 1;
    tick();
    tx_done = 0;
  endtask

  initial begin
    #1 rst_n = 0;
    tick();
    check_reset("reset");
    tick();
    rst_n = 1;
    write_word(6'd0, 32'h8C010004);
    write_word(6'd1, 32'h00000000);
    check("idle busy", busy, 0);

    launch(0, 7'd2, 8'd0);
    check("r1 busy", busy, 1);
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin
        start = 1; mode = 1; n_inst = 0; n_steps = 5;
        prog_we = 1; prog_addr = 6'd1; prog_data = 32'hFFFFFFFF;
      end
      byte_hs(full_stream[i], 0, $sformatf("r1 b%0d", i));
      if (i == 2) begin
        start = 0; prog_we = 0; mode = 0;
      end
    end
    check("r1 done", done, 1);
    check("r1 finish state", state, 8);
    tick();
    check("r1 done drop", done, 0);
    check("r1 idle busy", busy, 0);
    check("r1 idle state", state, 0);

    launch(1, 7'd0, 8'd2);
    mode = 0; n_steps = 0;
    byte_hs(8'h03, 0, "st b0");
    byte_hs(8'h07, 1, "st b1");
    check("st wait state", state, 6);
    rx_done = 1;
    repeat (259) tick();
    rx_done = 0;
    check("st 259 state", state, 6);
    check("st 259 count", step_count, 0);
    rx_done = 1;
    tick();
    rx_done = 0;
    check("st 260 count", step_count, 1);
    check("st 260 state", state, 5);
    byte_hs(8'h07, 0, "st b2");
    rx_done = 1;
    repeat (260) tick();
    rx_done = 0;
    check("st2 state", state, 7);
    check("st2 count", step_count, 2);
    byte_hs(8'h08, 0, "st b3");
    check("st done", done, 1);
    check("st final count", step_count, 2);
    tick();
    check("st idle busy", busy, 0);

    launch(1, 7'd0, 8'd0);
    byte_hs(8'h03, 0, "z b0");
    check("z skip resp", state, 7);
    byte_hs(8'h08, 0, "z b1");
    check("z done", done, 1);
    check("z count", step_count, 0);
    tick();

    launch(1, 7'd0, 8'd1);
    byte_hs(8'h03, 0, "rs b0");
    byte_hs(8'h07, 0, "rs b1");
    check("rs wait state", state, 6);
    rx_done = 1;
    repeat (10) tick();
    rx_done = 0;
    rst_n = 0;
    tick();
    check_reset("midrun");
    tick();
    check("midrun quiet", tx_start, 0);
    rst_n = 1;
    launch(0, 7'd2, 8'd0);
    for (int i = 0; i < 10; i++) byte_hs(full_stream[i], 0, $sformatf("r2 b%0d", i));
    check("r2 done", done, 1);
    tick();

    launch(0, 7'd0, 8'd0);
    check("to data", tx_data, 8'h02);
    repeat (60) tick();
    check("to early error", error, 0);
    check("to early busy", busy, 1);
`ifdef SEQ_TIMEOUT_EN
    repeat (60) tick();
    check("to error", error, 1);
    check("to busy", busy, 0);
    check("to state", state, 9);
    start = 1;
    tick();
    start = 0;
    tick();
    check("to sticky state", state, 9);
    check("to sticky error", error, 1);
    check("to no start", tx_start, 0);
`else
    repeat (200) tick();
    check("nowd error", error, 0);
    check("nowd busy", busy, 1);
    check("nowd state", state, 3);
`endif
    rst_n = 0;
    tick();
    check_reset("final");
    rst_n = 1;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
